// File: rtl/pcs_scr_pkg.sv
// Shared definitions for the 64B/66B transmit scrambler (x^58 + x^39 + 1).
// Also holds the constant function that folds the serial scrambler recurrence into per-bit XOR masks.
package pcs_scr_pkg;

  localparam int LFSR_WIDTH = 58;
  localparam int DATA_WIDTH = 64;
  localparam int TAP_A      = 39;
  localparam int TAP_B      = 58;
  localparam int HIST_WIDTH = LFSR_WIDTH + DATA_WIDTH;

  localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [1:0]            hdr;
    logic [DATA_WIDTH-1:0] data;
  } blk66_t;

  // Row n selects which bits of {data_in, state_in} XOR together to form out[n].
  // Taps landing inside the current block reuse the row of the output bit they refer to.
  function automatic logic [DATA_WIDTH-1:0][HIST_WIDTH-1:0] scr_masks();
    logic [DATA_WIDTH-1:0][HIST_WIDTH-1:0] m;
    int k_near;
    int k_far;
    m = '0;
    for (int n = 0; n < DATA_WIDTH; n++) begin
      m[n][LFSR_WIDTH+n] = 1'b1;
      k_near = n + TAP_B - TAP_A;
      k_far  = n;
      if (k_near < LFSR_WIDTH) m[n][k_near] = ~m[n][k_near];
      else                     m[n] = m[n] ^ m[k_near-LFSR_WIDTH];
      if (k_far < LFSR_WIDTH)  m[n][k_far] = ~m[n][k_far];
      else                     m[n] = m[n] ^ m[k_far-LFSR_WIDTH];
    end
    return m;
  endfunction

endpackage

// File: rtl/scr_lfsr_comb.sv
// One 64-bit step of the self-synchronising scrambler, purely combinational.
// The next state is the newest 58 scrambled bits.
module scr_lfsr_comb
  import pcs_scr_pkg::*;
(
  input  logic [LFSR_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam logic [DATA_WIDTH-1:0][HIST_WIDTH-1:0] MASK = scr_masks();

  logic [HIST_WIDTH-1:0] w_src;

  assign w_src = {data_in, state_in};

  always_comb begin
    data_out = '0;
    for (int n = 0; n < DATA_WIDTH; n++) begin
      data_out[n] = ^(w_src & MASK[n]);
    end
  end

  assign state_out = data_out[DATA_WIDTH-1 -: LFSR_WIDTH];

endmodule

// File: rtl/tx_scrambler_64b66b.sv
// 64B/66B transmit scrambler: scrambles the payload, forwards the header, and registers
// the result behind a 2-entry skid buffer so downstream backpressure never stalls a block.
module tx_scrambler_64b66b
  import pcs_scr_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED_VALUE = DEFAULT_SEED,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [1:0]            in_hdr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_scr_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  load_seed,
  output logic [1:0]            out_hdr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  blk_cnt
);

  logic [LFSR_WIDTH-1:0] r_lfsr;
  blk66_t                r_out;
  logic                  r_out_valid;
  blk66_t                r_skid;
  logic                  r_skid_valid;
  logic [CNT_WIDTH-1:0]  r_blk_cnt;

  logic                  w_accept;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_scr_data;
  logic [LFSR_WIDTH-1:0] w_state_next;
  blk66_t                w_blk;

  scr_lfsr_comb u_scr (
    .state_in  (r_lfsr),
    .data_in   (in_data),
    .data_out  (w_scr_data),
    .state_out (w_state_next)
  );

  // The skid entry is only ever occupied while the output entry is, so it alone means full.
  assign in_ready = ~r_skid_valid;
  assign w_accept = in_valid & in_ready;
  assign w_xfer   = r_out_valid & out_ready;

  always_comb begin
    w_blk.hdr  = in_hdr;
    w_blk.data = in_scr_en ? w_scr_data : in_data;
  end

  // A reload wins over the advance of a block accepted in the same cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED_VALUE;
    end else if (load_seed) begin
      r_lfsr <= SEED_VALUE;
    end else if (w_accept && in_scr_en) begin
      r_lfsr <= w_state_next;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_xfer) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_blk;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_blk;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
    end else if (w_xfer) begin
      r_blk_cnt <= r_blk_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign out_hdr   = r_out.hdr;
  assign out_data  = r_out.data;
  assign out_valid = r_out_valid;
  assign blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_tx_scrambler_64b66b.sv
// Self-checking bench for tx_scrambler_64b66b: directed vector table, load/reset corner
// sequences, and randomized flow against a bit-serial reference scrambler and descrambler.
module tb_tx_scrambler_64b66b;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_hdr = '0;
  logic [63:0] in_data = '0;
  logic        in_scr_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        load_seed = 1'b0;
  logic [1:0]  out_hdr;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] blk_cnt;

  logic        z_in_valid = 1'b0;
  logic        z_in_ready;
  logic        z_load_seed = 1'b0;
  logic [1:0]  z_out_hdr;
  logic [63:0] z_out_data;
  logic        z_out_valid;
  logic        z_out_ready = 1'b1;
  logic [3:0]  z_blk_cnt;

  always #5 CLK = ~CLK;

  tx_scrambler_64b66b dut (
    .CLK(CLK), .rst_n(rst_n), .in_hdr(in_hdr), .in_data(in_data), .in_scr_en(in_scr_en),
    .in_valid(in_valid), .in_ready(in_ready), .load_seed(load_seed), .out_hdr(out_hdr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .blk_cnt(blk_cnt)
  );

  // Zero-seed build with a narrow counter, for the all-zero stream and counter wrap.
  tx_scrambler_64b66b #(.SEED_VALUE(58'h0), .CNT_WIDTH(4)) dut0 (
    .CLK(CLK), .rst_n(rst_n), .in_hdr(in_hdr), .in_data(in_data), .in_scr_en(in_scr_en),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .load_seed(z_load_seed), .out_hdr(z_out_hdr),
    .out_data(z_out_data), .out_valid(z_out_valid), .out_ready(z_out_ready), .blk_cnt(z_blk_cnt)
  );

  typedef struct {
    logic [1:0]  hdr;
    logic [63:0] din;
    logic [63:0] dout;
  } exp_t;

  typedef struct {
    logic        en;
    logic [1:0]  hdr;
    logic [63:0] din;
    logic [63:0] dexp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [57:0] m_s = SEED;
  int          occ = 0;
  int          n_xfer = 0;
  logic        prev_stall = 1'b0;
  logic [65:0] prev_out = '0;
  logic        desc_on = 1'b0;
  logic [57:0] desc_h = '0;
  int          desc_n = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Serial scrambler straight from the recurrence: each scrambled bit is the data bit
  // XORed with the scrambled bits 39 and 58 positions earlier in the transmitted stream.
  function automatic void ref_scr(input logic [57:0] s, input logic [63:0] d,
                                  output logic [63:0] o, output logic [57:0] ns);
    logic h [0:121];
    for (int k = 0; k < 58; k++) h[k] = s[k];
    for (int n = 0; n < 64; n++) begin
      h[58+n] = d[n] ^ h[n+19] ^ h[n];
      o[n] = h[58+n];
    end
    for (int k = 0; k < 58; k++) ns[k] = h[64+k];
  endfunction

  // Matching descrambler: history is the received (scrambled) bits.
  function automatic void ref_descr(input logic [57:0] hist, input logic [63:0] r,
                                    output logic [63:0] d, output logic [57:0] nh);
    logic h [0:121];
    for (int k = 0; k < 58; k++) h[k] = hist[k];
    for (int n = 0; n < 64; n++) h[58+n] = r[n];
    for (int n = 0; n < 64; n++) d[n] = r[n] ^ h[n+19] ^ h[n];
    nh = r[63:6];
  endfunction

  task automatic drv(input logic v, input logic [1:0] h, input logic [63:0] d,
                     input logic en, input logic ld, input logic ordy);
    in_valid = v; in_hdr = h; in_data = d; in_scr_en = en; load_seed = ld; out_ready = ordy;
  endtask

  // One clock cycle: sample at negedge, check, update the reference, return at posedge+1.
  task automatic step();
    exp_t        e;
    logic        acc, xf;
    logic [63:0] o, dd;
    logic [57:0] ns, nh;
    @(negedge CLK);
    chk("out_valid", out_valid, occ > 0);
    chk("in_ready", in_ready, occ < 2);
    chk("blk_cnt", blk_cnt, n_xfer[31:0]);
    if (prev_stall) chk("stall_stable", {out_hdr, out_data}, prev_out);
    acc = in_valid & in_ready;
    xf  = out_valid & out_ready;
    if (xf) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_blk act=%h exp=none", {out_hdr, out_data});
      end else begin
        e = q.pop_front();
        chk("out_blk", {out_hdr, out_data}, {e.hdr, e.dout});
        if (desc_on) begin
          ref_descr(desc_h, out_data, dd, nh);
          desc_h = nh;
          if (desc_n > 0) chk("descr", dd, e.din);
          desc_n++;
        end
      end
      n_xfer++;
    end
    if (acc) begin
      e.hdr = in_hdr; e.din = in_data; e.dout = in_data;
      if (in_scr_en) begin
        ref_scr(m_s, in_data, o, ns);
        e.dout = o; m_s = ns;
      end
      q.push_back(e);
    end
    if (load_seed) m_s = SEED;
    occ = occ + int'(acc) - int'(xf);
    prev_stall = out_valid & ~out_ready;
    prev_out = {out_hdr, out_data};
    @(posedge CLK); #1;
  endtask

  vec_t        tv [4];
  logic [63:0] o_t;
  logic [57:0] s_t;
  int          sent, cyc, zc;
  logic [1:0]  zh;

  initial begin
    tv[0] = '{1'b1, 2'b01, 64'h0, 64'h03FF_FF80_0000_0000};
    tv[1] = '{1'b0, 2'b10, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    // After tv[0] the state holds only bits 33..51; tv[1] must not move it.
    ref_scr(58'h000F_FFFE_0000_0000, 64'h0, o_t, s_t);
    tv[2] = '{1'b1, 2'b00, 64'h0, o_t};
    ref_scr(s_t, 64'hFFFF_FFFF_FFFF_FFFF, o_t, s_t);
    tv[3] = '{1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, o_t};

    #22 rst_n = 1'b1;
    @(posedge CLK); #1;
    chk("rst_out", {out_hdr, out_data}, 66'h0);
    drv(0, 2'b00, 64'h0, 0, 0, 1);
    step();

    for (int i = 0; i < 4; i++) begin
      drv(1, tv[i].hdr, tv[i].din, tv[i].en, 0, 1);
      step();
      drv(0, 2'b00, 64'h0, 0, 0, 1);
      chk("tv_valid", out_valid, 1'b1);
      chk("tv_hdr", out_hdr, tv[i].hdr);
      chk("tv_data", out_data, tv[i].dexp);
      step();
    end

    // Reload coincident with an accept: that block uses the old state, the next the seed.
    drv(1, 2'b01, {$urandom, $urandom}, 1, 1, 1);
    step();
    drv(1, 2'b10, 64'h0, 1, 0, 1);
    step();
    drv(0, 2'b00, 64'h0, 0, 0, 1);
    chk("after_load", out_data, 64'h03FF_FF80_0000_0000);
    step();

    // Five stalled cycles under continuous input, then drain.
    for (int i = 0; i < 5; i++) begin
      drv(1, 2'($urandom), {$urandom, $urandom}, 1, 0, 0);
      step();
    end
    drv(0, 2'b00, 64'h0, 0, 0, 1);
    repeat (4) step();

    // Randomized stream into a reference descrambler started from an arbitrary state.
    desc_on = 1'b1; desc_h = {26'($urandom), $urandom}; desc_n = 0;
    sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 40000) begin
      drv(1'($urandom_range(0, 4) != 0), 2'($urandom), {$urandom, $urandom}, 1, 0,
          (cyc % 500 >= 5) && ($urandom_range(0, 3) != 0));
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    chk("rand_sent", sent, 10000);
    drv(0, 2'b00, 64'h0, 0, 0, 1);
    repeat (4) step();
    desc_on = 1'b0;

    // Mixed enables and occasional reloads, including while blocks sit in the skid.
    for (int i = 0; i < 2000; i++) begin
      drv(1'($urandom_range(0, 3) != 0), 2'($urandom), {$urandom, $urandom},
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0),
          1'($urandom_range(0, 2) != 0));
      step();
    end
    drv(0, 2'b00, 64'h0, 0, 0, 1);
    repeat (4) step();

    // Reset asserted while both entries are full.
    for (int i = 0; i < 3; i++) begin
      drv(1, 2'b01, {$urandom, $urandom}, 1, 0, 0);
      step();
    end
    #2 rst_n = 1'b0;
    drv(0, 2'b00, 64'h0, 0, 0, 0);
    #1;
    chk("rst_async_valid", out_valid, 1'b0);
    chk("rst_async_cnt", blk_cnt, 32'h0);
    q.delete(); occ = 0; n_xfer = 0; m_s = SEED; prev_stall = 1'b0;
    @(posedge CLK); #3 rst_n = 1'b1;
    @(posedge CLK); #1;
    step();
    drv(1, 2'b10, 64'h0, 1, 0, 1);
    step();
    drv(0, 2'b00, 64'h0, 0, 0, 0);
    chk("post_rst_data", out_data, 64'h03FF_FF80_0000_0000);
    step();

    // Zero-seed instance: all-zero payload stays zero, headers pass, counter wraps.
    drv(0, 2'b00, 64'h0, 1, 0, 0);
    z_load_seed = 1'b1;
    @(posedge CLK); #1;
    z_load_seed = 1'b0;
    zc = 0;
    for (int i = 0; i < 24; i++) begin
      z_in_valid = (i < 20);
      in_hdr = (i % 2 == 1) ? 2'b10 : 2'b01;
      in_data = 64'h0;
      @(negedge CLK);
      if (z_out_valid) begin
        zh = (zc % 2 == 1) ? 2'b10 : 2'b01;
        chk("zero_data", z_out_data, 64'h0);
        chk("zero_hdr", z_out_hdr, zh);
        zc++;
      end
      @(posedge CLK); #1;
    end
    z_in_valid = 1'b0;
    chk("zero_count", zc, 20);
    chk("zero_wrap", z_blk_cnt, 4'(zc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
